// File: rtl/fcc_argmin_unit.sv
// rtl/fcc_argmin_unit.sv - nearest-centroid selector over K streamed squared distances
// Tracks the running minimum per point and emits one registered label per K accepted samples.
module fcc_argmin_unit #(
    parameter int K     = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [39:0]      dist2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             abort,
    output logic             out_valid,
    output logic [IDX_W-1:0] best_idx,
    output logic [39:0]      best_dist,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      pt_count
);

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(K-1);

    logic [IDX_W:0]     cnt;
    logic [39:0]        min_d;
    logic [IDX_W-1:0]   min_i;
    logic [TAG_W-1:0]   tag_r;

    logic               first_smp;
    logic               last_smp;
    logic               cand_lt;
    logic [39:0]        fin_d;
    logic [IDX_W-1:0]   fin_i;
    logic [TAG_W-1:0]   fin_tag;

    // The first sample of a point seeds the minimum unconditionally; later ones
    // replace it only when strictly smaller, so ties keep the lowest index.
    always_comb begin
        first_smp = (cnt == '0);
        last_smp  = (cnt == LAST);
        cand_lt   = (dist2 < min_d);
        fin_d     = min_d;
        fin_i     = min_i;
        fin_tag   = first_smp ? in_tag : tag_r;
        if (first_smp) begin
            fin_d = dist2;
            fin_i = '0;
        end else if (cand_lt) begin
            fin_d = dist2;
            fin_i = cnt[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            min_d     <= '0;
            min_i     <= '0;
            tag_r     <= '0;
            out_valid <= 1'b0;
            best_idx  <= '0;
            best_dist <= '0;
            out_tag   <= '0;
            pt_count  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (abort) begin
                cnt <= '0;
            end else if (in_valid) begin
                min_d <= fin_d;
                min_i <= fin_i;
                if (first_smp) begin
                    tag_r <= in_tag;
                end
                if (last_smp) begin
                    cnt       <= '0;
                    best_dist <= fin_d;
                    best_idx  <= fin_i;
                    out_tag   <= fin_tag;
                    out_valid <= 1'b1;
                    pt_count  <= pt_count + 16'd1;
                end else begin
                    cnt <= cnt + (IDX_W+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fcc_argmin_unit.sv
// tb/tb_fcc_argmin_unit.sv - bench for fcc_argmin_unit, K=4 and K=1 instances driven in parallel
// Reference: collect each point's samples, pick the first minimum by a plain scan.
module tb_fcc_argmin_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [39:0] dist2;
    logic [15:0] in_tag;
    logic        abort;

    logic        ov4, ov1;
    logic [1:0]  idx4;
    logic [0:0]  idx1;
    logic [39:0] bd4, bd1;
    logic [15:0] tag4, tag1;
    logic [15:0] pc4, pc1;

    always #5 clk = ~clk;

    fcc_argmin_unit #(.K(4), .IDX_W(2), .TAG_W(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .dist2(dist2), .in_tag(in_tag),
        .abort(abort), .out_valid(ov4), .best_idx(idx4), .best_dist(bd4),
        .out_tag(tag4), .pt_count(pc4)
    );

    fcc_argmin_unit #(.K(1), .IDX_W(1), .TAG_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .dist2(dist2), .in_tag(in_tag),
        .abort(abort), .out_valid(ov1), .best_idx(idx1), .best_dist(bd1),
        .out_tag(tag1), .pt_count(pc1)
    );

    int          n_cmp = 0;
    int          n_bad = 0;

    int          kk[2] = '{4, 1};
    int          n[2];
    logic [39:0] sbuf[2][4];
    logic [15:0] ftag[2];
    logic        e_valid[2];
    int          e_idx[2];
    logic [39:0] e_dist[2];
    logic [15:0] e_tag[2];
    int          e_cnt[2];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model(input int u, input logic v, input logic [39:0] d,
                         input logic [15:0] t, input logic ab, input logic r);
        int bi;
        logic [39:0] bdist;
        e_valid[u] = 1'b0;
        if (r) begin
            n[u] = 0; e_idx[u] = 0; e_dist[u] = '0; e_tag[u] = '0; e_cnt[u] = 0;
        end else if (ab) begin
            n[u] = 0;
        end else if (v) begin
            if (n[u] == 0) ftag[u] = t;
            sbuf[u][n[u]] = d;
            n[u]++;
            if (n[u] == kk[u]) begin
                bi = 0;
                bdist = sbuf[u][0];
                for (int i = 1; i < kk[u]; i++)
                    if (sbuf[u][i] < bdist) begin
                        bdist = sbuf[u][i];
                        bi = i;
                    end
                e_valid[u] = 1'b1;
                e_idx[u]   = bi;
                e_dist[u]  = bdist;
                e_tag[u]   = ftag[u];
                e_cnt[u]   = (e_cnt[u] + 1) % 65536;
                n[u]       = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [39:0] d, input logic [15:0] t,
                        input logic ab, input logic r);
        in_valid = v; dist2 = d; in_tag = t; abort = ab; rst = r;
        @(posedge clk);
        #1;
        model(0, v, d, t, ab, r);
        model(1, v, d, t, ab, r);
        chk("k4_out_valid", 64'(ov4),  64'(e_valid[0]));
        chk("k4_best_idx",  64'(idx4), 64'(e_idx[0]));
        chk("k4_best_dist", 64'(bd4),  64'(e_dist[0]));
        chk("k4_out_tag",   64'(tag4), 64'(e_tag[0]));
        chk("k4_pt_count",  64'(pc4),  64'(e_cnt[0]));
        chk("k1_out_valid", 64'(ov1),  64'(e_valid[1]));
        chk("k1_best_idx",  64'(idx1), 64'(e_idx[1]));
        chk("k1_best_dist", 64'(bd1),  64'(e_dist[1]));
        chk("k1_out_tag",   64'(tag1), 64'(e_tag[1]));
        chk("k1_pt_count",  64'(pc1),  64'(e_cnt[1]));
    endtask

    task automatic idle();
        step(1'b0, 40'(($urandom() << 8) ^ $urandom()), 16'($urandom()), 1'b0, 1'b0);
    endtask

    logic [63:0] rv;
    logic [39:0] dd;

    initial begin
        for (int u = 0; u < 2; u++) begin
            n[u] = 0; ftag[u] = '0; e_valid[u] = 1'b0;
            e_idx[u] = 0; e_dist[u] = '0; e_tag[u] = '0; e_cnt[u] = 0;
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 40'd77, 16'h77, 1'b1, 1'b1);
        idle();

        step(1'b1, 40'd100, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 40'd50,  16'h0011, 1'b0, 1'b0);
        step(1'b1, 40'd75,  16'h0011, 1'b0, 1'b0);
        step(1'b1, 40'd50,  16'h0011, 1'b0, 1'b0);
        idle(); idle();

        foreach (kk[i]) ;
        step(1'b1, 40'd9, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 40'd8, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 40'd7, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 40'd6, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 40'd1, 16'h000B, 1'b0, 1'b0);
        step(1'b1, 40'd2, 16'h000B, 1'b0, 1'b0);
        step(1'b1, 40'd3, 16'h000B, 1'b0, 1'b0);
        step(1'b1, 40'd4, 16'h000B, 1'b0, 1'b0);
        idle();

        for (int s = 0; s < 4; s++) begin
            int nb;
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) idle();
            step(1'b1, 40'hFF_FFFF_FFFF, 16'h00F0 + 16'(s), 1'b0, 1'b0);
        end
        idle(); idle();

        step(1'b1, 40'd11, 16'h0004, 1'b0, 1'b0);
        step(1'b1, 40'd12, 16'h0004, 1'b0, 1'b0);
        step(1'b1, 40'd1,  16'h0004, 1'b1, 1'b0);
        step(1'b1, 40'd30, 16'h0005, 1'b0, 1'b0);
        step(1'b1, 40'd20, 16'h0005, 1'b0, 1'b0);
        step(1'b1, 40'd10, 16'h0005, 1'b0, 1'b0);
        step(1'b1, 40'd40, 16'h0005, 1'b0, 1'b0);
        idle();
        step(1'b1, 40'd3, 16'h0006, 1'b0, 1'b0);
        step(1'b1, 40'd2, 16'h0006, 1'b0, 1'b0);
        step(1'b1, 40'd1, 16'h0006, 1'b0, 1'b0);
        step(1'b1, 40'd0, 16'h0006, 1'b1, 1'b0);
        idle(); idle();

        step(1'b1, 40'd8, 16'h0007, 1'b0, 1'b0);
        step(1'b1, 40'd9, 16'h0007, 1'b0, 1'b0);
        step(1'b1, 40'd4, 16'h0007, 1'b0, 1'b0);
        step(1'b0, 40'd0, 16'h0000, 1'b1, 1'b1);
        idle();
        for (int s = 0; s < 4; s++) step(1'b1, 40'd5, 16'h0008, 1'b0, 1'b0);
        idle();

        step(1'b1, 40'd7, 16'h0021, 1'b0, 1'b0);
        step(1'b1, 40'd3, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 40'd9, 16'h0023, 1'b0, 1'b0);
        idle();

        for (int s = 0; s < 400; s++) begin
            rv = {$urandom(), $urandom()};
            dd = ($urandom_range(0, 1) == 0) ? 40'($urandom_range(0, 7)) : rv[39:0];
            step($urandom_range(0, 3) != 0, dd, 16'($urandom()),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
